// File: rtl/emu_time_manager_multi_if.sv
// Bus between the emulation time manager and its environment: requests, controls, time outputs.
interface emu_time_manager_multi_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DT_WIDTH   = 32,
    parameter int unsigned TIME_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32
);
    localparam int unsigned SRC_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ*DT_WIDTH-1:0] dt_req;
    logic [N_REQ-1:0]          req_en;
    logic                      pause;
    logic                      step_req;
    logic                      stop_en;
    logic [TIME_WIDTH-1:0]     stop_time;
    logic                      clear_halt;
    logic [TIME_WIDTH-1:0]     emu_time;
    logic [DT_WIDTH-1:0]       emu_dt;
    logic [SRC_WIDTH-1:0]      dt_src;
    logic                      running;
    logic                      halted;
    logic                      step_ack;
    logic [CNT_WIDTH-1:0]      adv_count;

    modport master (
        output dt_req, req_en, pause, step_req, stop_en, stop_time, clear_halt,
        input  emu_time, emu_dt, dt_src, running, halted, step_ack, adv_count
    );

    modport slave (
        input  dt_req, req_en, pause, step_req, stop_en, stop_time, clear_halt,
        output emu_time, emu_dt, dt_src, running, halted, step_ack, adv_count
    );
endinterface

// File: rtl/emu_time_manager_multi.sv
// Emulation time manager: min-reduces enabled dt requests, clamps against an optional stop
// time, and accumulates emulation time with run / pause / single-step / halt control.
module emu_time_manager_multi #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DT_WIDTH     = 32,
    parameter int unsigned TIME_WIDTH   = 64,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned START_PAUSED = 0
) (
    input logic                      emu_clk,
    input logic                      emu_rst_n,
    emu_time_manager_multi_if.slave  bus
);
    localparam int unsigned SRC_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StRun, StPaused, StHalted} state_e;

    localparam state_e RESET_STATE = (START_PAUSED != 0) ? StPaused : StRun;

    state_e                state_q, state_d;
    logic [TIME_WIDTH-1:0] emu_time_q;
    logic [CNT_WIDTH-1:0]  adv_count_q;
    logic                  step_ack_q, step_ack_d;

    logic [DT_WIDTH-1:0]   dt_min;
    logic [SRC_WIDTH-1:0]  dt_src;
    logic                  any_en;
    logic [TIME_WIDTH-1:0] rem;
    logic [TIME_WIDTH-1:0] dt_min_ext;
    logic                  stop_ahead;
    logic                  expired;
    logic                  hit;
    logic [DT_WIDTH-1:0]   dt_clamp;
    logic                  step_go;
    logic                  adv;
    logic [DT_WIDTH-1:0]   emu_dt;

    // Unsigned minimum over enabled channels; strict '<' keeps the lowest index on ties.
    always_comb begin
        dt_min = '1;
        dt_src = '0;
        any_en = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.req_en[i] && (!any_en || (bus.dt_req[i*DT_WIDTH +: DT_WIDTH] < dt_min))) begin
                dt_min = bus.dt_req[i*DT_WIDTH +: DT_WIDTH];
                dt_src = SRC_WIDTH'(i);
                any_en = 1'b1;
            end
        end
    end

    // Stop-time clamp and advance qualification; a zero dt never counts as an advance.
    always_comb begin
        stop_ahead = bus.stop_time > emu_time_q;
        rem        = bus.stop_time - emu_time_q;
        dt_min_ext = TIME_WIDTH'(dt_min);
        expired    = bus.stop_en && !stop_ahead;
        hit        = bus.stop_en && stop_ahead && (rem <= dt_min_ext);
        if (hit) begin
            dt_clamp = rem[DT_WIDTH-1:0];
        end else if (expired) begin
            dt_clamp = '0;
        end else begin
            dt_clamp = dt_min;
        end
        step_go = (state_q == StPaused) && bus.step_req;
        adv     = (((state_q == StRun) && !bus.pause) || step_go) && !expired &&
                  (dt_clamp != '0);
        emu_dt  = adv ? dt_clamp : '0;
    end

    // Next-state logic and step acknowledge generation.
    always_comb begin
        state_d    = state_q;
        step_ack_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.pause) begin
                    state_d = StPaused;
                end else if (expired || (adv && hit)) begin
                    state_d = StHalted;
                end
            end
            StPaused: begin
                step_ack_d = step_go && adv;
                if (step_go && (expired || (adv && hit))) begin
                    state_d = StHalted;
                end else if (!bus.pause) begin
                    state_d = StRun;
                end
            end
            StHalted: begin
                if (bus.clear_halt && (!bus.stop_en || stop_ahead)) begin
                    state_d = bus.pause ? StPaused : StRun;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // State, time, counter and acknowledge registers.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q     <= RESET_STATE;
            emu_time_q  <= '0;
            adv_count_q <= '0;
            step_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_ack_q <= step_ack_d;
            if (adv) begin
                emu_time_q  <= emu_time_q + TIME_WIDTH'(emu_dt);
                adv_count_q <= adv_count_q + 1'b1;
            end
        end
    end

    assign bus.emu_time  = emu_time_q;
    assign bus.emu_dt    = emu_dt;
    assign bus.dt_src    = dt_src;
    assign bus.running   = (state_q == StRun);
    assign bus.halted    = (state_q == StHalted);
    assign bus.step_ack  = step_ack_q;
    assign bus.adv_count = adv_count_q;
endmodule

// File: tb/tb_emu_time_manager_multi.sv
// Bench for emu_time_manager_multi: two instances (run-start and paused-start) share stimulus
// and are compared every cycle against a behavioural model of the time manager.
module tb_emu_time_manager_multi;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 64;
    localparam int unsigned CW = 32;

    localparam int S_RUN    = 0;
    localparam int S_PAUSED = 1;
    localparam int S_HALTED = 2;

    logic emu_clk   = 1'b0;
    logic emu_rst_n = 1'b0;

    always #5 emu_clk = ~emu_clk;

    logic [N*DW-1:0] dt_req;
    logic [DW-1:0]   dt [N];
    logic [N-1:0]    req_en;
    logic            pause, step_req, stop_en, clear_halt;
    logic [TW-1:0]   stop_time;

    emu_time_manager_multi_if #(.N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(TW), .CNT_WIDTH(CW)) bus0 ();
    emu_time_manager_multi_if #(.N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(TW), .CNT_WIDTH(CW)) bus1 ();

    assign bus0.dt_req = dt_req;     assign bus1.dt_req = dt_req;
    assign bus0.req_en = req_en;     assign bus1.req_en = req_en;
    assign bus0.pause = pause;       assign bus1.pause = pause;
    assign bus0.step_req = step_req; assign bus1.step_req = step_req;
    assign bus0.stop_en = stop_en;   assign bus1.stop_en = stop_en;
    assign bus0.stop_time = stop_time;   assign bus1.stop_time = stop_time;
    assign bus0.clear_halt = clear_halt; assign bus1.clear_halt = clear_halt;

    emu_time_manager_multi #(
        .N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(TW), .CNT_WIDTH(CW), .START_PAUSED(0)
    ) dut0 (
        .emu_clk   (emu_clk),
        .emu_rst_n (emu_rst_n),
        .bus       (bus0)
    );

    emu_time_manager_multi #(
        .N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(TW), .CNT_WIDTH(CW), .START_PAUSED(1)
    ) dut1 (
        .emu_clk   (emu_clk),
        .emu_rst_n (emu_rst_n),
        .bus       (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state per instance.
    longint unsigned m_time [2];
    int unsigned     m_cnt  [2];
    int              m_state[2];
    bit              m_ack  [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic sample(input int d, output logic [63:0] t, output logic [63:0] dtv,
                          output logic [63:0] src, output logic [63:0] cnt, output logic run,
                          output logic hlt, output logic ack);
        if (d == 0) begin
            t = bus0.emu_time; dtv = 64'(bus0.emu_dt); src = 64'(bus0.dt_src);
            cnt = 64'(bus0.adv_count); run = bus0.running; hlt = bus0.halted; ack = bus0.step_ack;
        end else begin
            t = bus1.emu_time; dtv = 64'(bus1.emu_dt); src = 64'(bus1.dt_src);
            cnt = 64'(bus1.adv_count); run = bus1.running; hlt = bus1.halted; ack = bus1.step_ack;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_time[d]  = 0;
            m_cnt[d]   = 0;
            m_ack[d]   = 1'b0;
            m_state[d] = (d == 1) ? S_PAUSED : S_RUN;
        end
    endtask

    // One clock: compare outputs against the model mid-cycle, then let the model take the edge.
    task automatic cycle();
        longint unsigned n_time[2];
        int unsigned     n_cnt[2];
        int              n_state[2];
        bit              n_ack[2];
        for (int i = 0; i < N; i++) dt_req[i*DW +: DW] = dt[i];
        @(negedge emu_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            longint unsigned t, mn, eff, rem, exp_dt;
            int unsigned src;
            bit found, expired, hit, want, adv;
            logic [63:0] g_t, g_dt, g_src, g_cnt;
            logic g_run, g_hlt, g_ack;
            t = m_time[d];
            mn = 64'hFFFF_FFFF; src = 0; found = 0;
            for (int i = 0; i < N; i++) begin
                if (req_en[i] && (!found || longint'(dt[i]) < mn)) begin
                    mn = longint'(dt[i]); src = i; found = 1;
                end
            end
            eff = mn; expired = 0; hit = 0;
            if (stop_en) begin
                if (stop_time > t) begin
                    rem = stop_time - t;
                    if (rem <= mn) begin eff = rem; hit = 1; end
                end else begin
                    eff = 0; expired = 1;
                end
            end
            want = (m_state[d] == S_RUN && !pause) || (m_state[d] == S_PAUSED && step_req);
            adv = want && !expired && (eff != 0);
            exp_dt = adv ? eff : 0;

            sample(d, g_t, g_dt, g_src, g_cnt, g_run, g_hlt, g_ack);
            check($sformatf("d%0d emu_time", d), g_t, t);
            check($sformatf("d%0d emu_dt", d), g_dt, exp_dt);
            check($sformatf("d%0d dt_src", d), g_src, 64'(src));
            check($sformatf("d%0d adv_count", d), g_cnt, 64'(m_cnt[d]));
            check($sformatf("d%0d running", d), 64'(g_run), 64'(m_state[d] == S_RUN));
            check($sformatf("d%0d halted", d), 64'(g_hlt), 64'(m_state[d] == S_HALTED));
            check($sformatf("d%0d step_ack", d), 64'(g_ack), 64'(m_ack[d]));

            n_time[d] = adv ? t + exp_dt : t;
            n_cnt[d]  = adv ? m_cnt[d] + 1 : m_cnt[d];
            n_ack[d]  = (m_state[d] == S_PAUSED) && step_req && adv;
            n_state[d] = m_state[d];
            case (m_state[d])
                S_RUN: begin
                    if (pause) n_state[d] = S_PAUSED;
                    else if (expired || (adv && hit)) n_state[d] = S_HALTED;
                end
                S_PAUSED: begin
                    if (step_req && (expired || (adv && hit))) n_state[d] = S_HALTED;
                    else if (!pause) n_state[d] = S_RUN;
                end
                default: begin
                    if (clear_halt && (!stop_en || stop_time > t))
                        n_state[d] = pause ? S_PAUSED : S_RUN;
                end
            endcase
        end
        @(posedge emu_clk);
        for (int d = 0; d < 2; d++) begin
            m_time[d] = n_time[d]; m_cnt[d] = n_cnt[d];
            m_state[d] = n_state[d]; m_ack[d] = n_ack[d];
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic check_reset_values();
        check("rst d0 emu_time", bus0.emu_time, 64'd0);
        check("rst d0 adv_count", 64'(bus0.adv_count), 64'd0);
        check("rst d0 step_ack", 64'(bus0.step_ack), 64'd0);
        check("rst d0 running", 64'(bus0.running), 64'd1);
        check("rst d1 emu_time", bus1.emu_time, 64'd0);
        check("rst d1 adv_count", 64'(bus1.adv_count), 64'd0);
        check("rst d1 step_ack", 64'(bus1.step_ack), 64'd0);
        check("rst d1 running", 64'(bus1.running), 64'd0);
        check("rst d1 halted", 64'(bus1.halted), 64'd0);
    endtask

    // Assert reset between clock edges and check the outputs before any edge arrives.
    task automatic async_reset();
        @(negedge emu_clk);
        #2;
        emu_rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge emu_clk);
        #1;
        emu_rst_n = 1'b1;
    endtask

    task automatic set_req(input int a, input int b, input int c, input int e);
        dt[0] = DW'(a); dt[1] = DW'(b); dt[2] = DW'(c); dt[3] = DW'(e);
    endtask

    initial begin
        set_req(40, 7, 7, 90);
        req_en = 4'b1111; pause = 0; step_req = 0; stop_en = 0; clear_halt = 0;
        stop_time = '0;
        model_reset();
        repeat (2) @(negedge emu_clk);
        check_reset_values();
        @(posedge emu_clk);
        #1;
        emu_rst_n = 1'b1;

        // Min-reduce, masking, nothing enabled.
        run(3);
        req_en = 4'b1001; run(1);
        req_en = 4'b0000; run(1);
        async_reset();

        // Stop clamp, failed clear, successful clear after moving the stop time.
        req_en = 4'b1111; stop_en = 1; stop_time = 64'd20;
        run(5);
        clear_halt = 1; run(1); clear_halt = 0; run(1);
        stop_time = 64'd50;
        clear_halt = 1; run(1); clear_halt = 0; run(2);

        // Pause and three single steps.
        stop_en = 0; pause = 1; run(3);
        repeat (3) begin
            step_req = 1; run(1); step_req = 0; run(1);
        end
        // Step together with pause release.
        step_req = 1; pause = 0; run(1); step_req = 0; run(2);

        // Expired immediately after reset.
        async_reset();
        stop_en = 1; stop_time = 64'd0; run(3);
        stop_en = 0; clear_halt = 1; run(1); clear_halt = 0; run(1);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++)
                dt[i] = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom_range(1, 20));
            req_en = ($urandom_range(0, 19) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            pause = ($urandom_range(0, 3) == 0);
            step_req = ($urandom_range(0, 2) == 0);
            clear_halt = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) stop_en = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 4) == 0)
                    stop_time = m_time[0] - 64'($urandom_range(0, 5));
                else
                    stop_time = m_time[0] + 64'($urandom_range(0, 60));
            end
            cycle();
            if (n % 500 == 250) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/emu_time_manager_multi.md
Name: emu_time_manager_multi

Overview:
- Parametrised successor to the generated emulation time manager.
- Min-reduces N_REQ timestep requests, with a per-channel enable mask, and accumulates emulation time.
- Adds pause, single-step with acknowledge, and stop-time halting with exact landing on the stop time.
- Sits at the top of the emulator and drives emu_dt/emu_time to all analog/digital models.

Parameters:
- N_REQ, 4, number of dt requestors (≥1).
- DT_WIDTH, 32, width of each dt request and emu_dt.
- TIME_WIDTH, 64, width of emu_time and stop_time (≥ DT_WIDTH).
- CNT_WIDTH, 32, width of the advance counter.
- START_PAUSED, 0, 1 means the block leaves reset in PAUSED instead of RUN.

Ports:
- emu_clk  in  1  emulator clock.
- emu_rst_n  in  1  asynchronous, active-low reset.
- dt_req  in  N_REQ*DT_WIDTH  packed requests; channel i occupies bits [i*DT_WIDTH +: DT_WIDTH].
- req_en  in  N_REQ  per-channel enable; disabled channels are ignored.
- pause  in  1  level; requests the PAUSED state.
- step_req  in  1  single-cycle pulse; one advance while PAUSED.
- stop_en  in  1  enables the stop-time limit.
- stop_time  in  TIME_WIDTH  absolute halt time, unsigned.
- clear_halt  in  1  pulse; leave HALTED.
- emu_time  out  TIME_WIDTH  current emulation time.
- emu_dt  out  DT_WIDTH  effective dt this cycle (combinational).
- dt_src  out  $clog2(N_REQ) (min 1)  index of the winning channel.
- running  out  1  state==RUN.
- halted  out  1  state==HALTED.
- step_ack  out  1  one-cycle pulse after a completed step.
- adv_count  out  CNT_WIDTH  number of cycles with emu_dt≠0.

Behaviour:
- Reset (async assert, sync release): emu_time=0, adv_count=0, step_ack=0, state=RUN (PAUSED if START_PAUSED).
- dt_min:
  - Unsigned minimum over enabled channels; ties go to the lowest index.
  - No channel enabled: dt_min = all-ones, dt_src=0.
  - dt_src is valid every cycle regardless of state.
- Clamp:
  - rem = stop_time − emu_time (TIME_WIDTH, unsigned), evaluated only when stop_en=1 and stop_time>emu_time.
  - If rem ≤ dt_min: dt_clamp = rem (fits in DT_WIDTH) and hit=1.
  - Otherwise dt_clamp = dt_min.
  - stop_en=1 with stop_time ≤ emu_time: dt_clamp=0 and expired=1.
- adv: (RUN & !pause & !expired) | (PAUSED & step_req & !expired).
- emu_dt: dt_clamp when adv=1, else 0. Combinational, same-cycle, so models advance in lockstep.
- On posedge when adv=1:
  - emu_time += emu_dt, wrapping modulo 2^TIME_WIDTH.
  - adv_count += 1, wrapping.
- States:
  - RUN:
    - pause=1 → PAUSED; no advance in that cycle.
    - expired → HALTED.
    - adv & hit → HALTED.
  - PAUSED:
    - pause=0 → RUN.
    - step_req & !expired: advance one dt, step_ack=1 next cycle, remain PAUSED (→HALTED if hit).
    - step_req & expired: → HALTED, no step_ack.
    - step_req and pause=0 in the same cycle: step_req is honoured; next state RUN.
  - HALTED:
    - emu_dt=0; step_req and pause are ignored.
    - clear_halt & (!stop_en | stop_time>emu_time) → PAUSED if pause=1, else RUN.
    - clear_halt while the condition is false: stay HALTED.
- step_ack:
  - Registered; exactly one cycle, on the cycle after the advancing step edge.
  - Never asserted from RUN.
- stop_time may change at any time; the change takes effect in the same cycle's clamp.
- Reset mid-operation: immediate return to the reset values; no pending step_ack survives.
- dt_req values of 0 are legal. They give emu_dt=0, no time change, adv=0, and no count increment.

Test Plan:
- Min-reduce: N_REQ=4, dt_req={40,7,7,90}, req_en=4'b1111, RUN → emu_dt=7, dt_src=1, emu_time 0→7→14.
- Mask: same requests, req_en=4'b1001 → emu_dt=40, dt_src=0. Then req_en=0 → emu_dt=32'hFFFFFFFF.
- Stop clamp:
  - stop_en=1, stop_time=20, dt_min=7 → emu_time 7, 14, 20 (emu_dt=6), then halted=1 and emu_dt=0.
  - clear_halt with stop_time still 20 → stays HALTED.
  - Set stop_time=50, then clear_halt → RUN resumes at 20.
- Pause/step:
  - pause=1 → emu_dt=0 and emu_time frozen.
  - Three step_req pulses (dt=7) → emu_time +21, three step_ack pulses each one cycle late, adv_count +3.
- Expired/simultaneous:
  - stop_en=1, stop_time=0 right after reset → HALTED next cycle, emu_time=0.
  - In PAUSED, step_req together with pause deassert → one advance, step_ack=1, state RUN.
- Async reset: assert emu_rst_n=0 mid-run without a clock edge → emu_time=0, adv_count=0, step_ack=0 immediately. Check both START_PAUSED=0 and START_PAUSED=1.
